// File: rtl/i2c_regmap_pkg.sv
// Shared types and constants for the I2C register-map controller.
package i2c_regmap_pkg;

    localparam int DATA_W = 8;

    // Byte returned on a tx request that is not part of a register read
    localparam logic [DATA_W-1:0] IDLE_TX_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GET_PTR    = 2'd1,
        ST_WRITE_DATA = 2'd2,
        ST_READ_DATA  = 2'd3
    } state_e;

endpackage

// File: rtl/regmap_regfile.sv
// Register storage: I2C write port (wins over core on the same index),
// core write port, combinational core read, registered tx read port.
module regmap_regfile
    import i2c_regmap_pkg::*;
#(
    parameter int                NUM_REGS  = 16,
    parameter int                PTR_W     = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = 8'h00
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i2c_we,
    input  logic [PTR_W-1:0]  i2c_addr,
    input  logic [DATA_W-1:0] i2c_wdata,
    input  logic              core_we,
    input  logic [PTR_W-1:0]  core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              rd_req,
    input  logic              rd_en,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic                            tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0]               tx_data_q, tx_data_d;

    // Next register contents; I2C write applied last so it wins a same-index collision
    always_comb begin
        regs_d = regs_q;
        if (core_we) regs_d[core_addr] = core_wdata;
        if (i2c_we)  regs_d[i2c_addr]  = i2c_wdata;
    end

    // tx byte sampled from next-state storage so same-cycle writes are visible
    always_comb begin
        tx_valid_d = rd_req;
        tx_data_d  = tx_data_q;
        if (rd_req) tx_data_d = rd_en ? regs_d[rd_addr] : IDLE_TX_BYTE;
    end

    // Storage and tx output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs_q     <= {NUM_REGS{RESET_VAL}};
            tx_valid_q <= 1'b0;
            tx_data_q  <= IDLE_TX_BYTE;
        end else begin
            regs_q     <= regs_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign core_rdata = regs_q[core_addr];
    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;

endmodule

// File: rtl/i2c_regmap_ctrl.sv
// I2C byte-stream to register-map sequencer: pointer byte, auto-increment
// writes and reads, plus a local core access port.
// Optional: define I2C_REGMAP_RO_PROTECT_EN to make RO_MASK registers
// read-only from the I2C side.
module i2c_regmap_ctrl
    import i2c_regmap_pkg::*;
#(
    parameter int                  NUM_REGS  = 16,
    parameter logic [DATA_W-1:0]   RESET_VAL = 8'h00,
    parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
    localparam int                 PTR_W     = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bus_start,
    input  logic              bus_dir,
    input  logic              bus_stop,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_req,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic [PTR_W-1:0]  core_addr,
    output logic [7:0]        core_rdata,
    input  logic              core_we,
    input  logic [7:0]        core_wdata,
    output logic              wr_strobe,
    output logic [PTR_W-1:0]  wr_addr,
    output logic              busy,
    output logic [PTR_W-1:0]  ptr
);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               wr_strobe_q, wr_strobe_d;
    logic [PTR_W-1:0]   wr_addr_q, wr_addr_d;
    logic               bus_evt;
    logic               ro_block;
    logic               i2c_we;
    logic               rd_en;

    // A START/STOP cycle swallows any byte event in the same cycle
    assign bus_evt = bus_start | bus_stop;

`ifdef I2C_REGMAP_RO_PROTECT_EN
    assign ro_block = RO_MASK[ptr_q];
`else
    logic unused_ro_mask;
    assign unused_ro_mask = ^RO_MASK;
    assign ro_block       = 1'b0;
`endif

    assign i2c_we = (state_q == ST_WRITE_DATA) && rx_valid && !bus_evt && !ro_block;
    assign rd_en  = (state_q == ST_READ_DATA) && !bus_evt;

    // Next-state, pointer and write-strobe logic
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        wr_strobe_d = i2c_we;
        wr_addr_d   = i2c_we ? ptr_q : wr_addr_q;
        if (bus_start) begin
            state_d = bus_dir ? ST_READ_DATA : ST_GET_PTR;
        end else if (bus_stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_GET_PTR: if (rx_valid) begin
                    ptr_d   = rx_data[PTR_W-1:0];
                    state_d = ST_WRITE_DATA;
                end
                // Pointer advances even when a read-only write is dropped
                ST_WRITE_DATA: if (rx_valid) ptr_d = ptr_q + PTR_W'(1);
                ST_READ_DATA:  if (tx_req)   ptr_d = ptr_q + PTR_W'(1);
                default: ;
            endcase
        end
    end

    // Controller state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    regmap_regfile #(
        .NUM_REGS  (NUM_REGS),
        .PTR_W     (PTR_W),
        .RESET_VAL (RESET_VAL)
    ) u_regfile (
        .clock      (clock),
        .reset      (reset),
        .i2c_we     (i2c_we),
        .i2c_addr   (ptr_q),
        .i2c_wdata  (rx_data),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .rd_req     (tx_req),
        .rd_en      (rd_en),
        .rd_addr    (ptr_q),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data)
    );

    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign ptr       = ptr_q;

endmodule

// File: tb/tb_i2c_regmap_ctrl.sv
// Scoreboard bench for i2c_regmap_ctrl: stimulus pushes expected tx bytes and
// write strobes into queues; a negedge monitor pops and compares them.
module tb_i2c_regmap_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       bus_start, bus_dir, bus_stop, rx_valid, tx_req, core_we;
    logic [7:0] rx_data, core_wdata;
    logic [3:0] core_addr;
    logic       tx_valid, wr_strobe, busy;
    logic [7:0] tx_data, core_rdata;
    logic [3:0] wr_addr, ptr;

    typedef struct {
        logic [7:0] val;
        int         cyc;
    } exp_t;

    exp_t tx_q[$];
    exp_t wr_q[$];
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;
    int   m_chk = 0, m_fail = 0;

    i2c_regmap_ctrl #(.NUM_REGS(16), .RESET_VAL(8'h00), .RO_MASK(16'h0001)) dut (
        .clock(clock), .reset(reset), .bus_start(bus_start), .bus_dir(bus_dir),
        .bus_stop(bus_stop), .rx_valid(rx_valid), .rx_data(rx_data), .tx_req(tx_req),
        .tx_valid(tx_valid), .tx_data(tx_data), .core_addr(core_addr),
        .core_rdata(core_rdata), .core_we(core_we), .core_wdata(core_wdata),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .busy(busy), .ptr(ptr)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every output event must match the head of its queue, on time
    always @(negedge clock) begin
        if (!reset) begin
            if (tx_valid) begin
                m_chk++;
                if (tx_q.size() == 0) begin
                    m_fail++;
                    $display("FAIL tx_unexpected: got tx_data=%h at cyc %0d, none expected", tx_data, cyc);
                end else begin
                    exp_t e;
                    e = tx_q.pop_front();
                    if (tx_data !== e.val || cyc != e.cyc) begin
                        m_fail++;
                        $display("FAIL tx_data: got %h at cyc %0d, expected %h at cyc %0d", tx_data, cyc, e.val, e.cyc);
                    end
                end
            end
            if (wr_strobe) begin
                m_chk++;
                if (wr_q.size() == 0) begin
                    m_fail++;
                    $display("FAIL wr_unexpected: got wr_addr=%0d at cyc %0d, none expected", wr_addr, cyc);
                end else begin
                    exp_t e;
                    e = wr_q.pop_front();
                    if ({4'h0, wr_addr} !== e.val || cyc != e.cyc) begin
                        m_fail++;
                        $display("FAIL wr_addr: got %0d at cyc %0d, expected %0d at cyc %0d", wr_addr, cyc, e.val, e.cyc);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic dir);
        bus_start = 1'b1; bus_dir = dir;
        tick();
        bus_start = 1'b0;
    endtask

    task automatic stop();
        bus_stop = 1'b1;
        tick();
        bus_stop = 1'b0;
    endtask

    task automatic rx(input logic [7:0] b, input bit strobe, input logic [3:0] a);
        exp_t e;
        if (strobe) begin
            e.val = {4'h0, a}; e.cyc = cyc + 1;
            wr_q.push_back(e);
        end
        rx_valid = 1'b1; rx_data = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic treq(input logic [7:0] exp);
        exp_t e;
        e.val = exp; e.cyc = cyc + 1;
        tx_q.push_back(e);
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
    endtask

    task automatic cwrite(input logic [3:0] a, input logic [7:0] d);
        core_we = 1'b1; core_addr = a; core_wdata = d;
        tick();
        core_we = 1'b0;
    endtask

    task automatic creg(input logic [3:0] a, input logic [7:0] exp);
        core_addr = a;
        #1;
        check($sformatf("reg%0d", a), core_rdata, exp);
    endtask

    task automatic check_all_zero();
        for (int i = 0; i < 16; i++) creg(4'(i), 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        bus_start = 0; bus_dir = 0; bus_stop = 0; rx_valid = 0; rx_data = 0;
        tx_req = 0; core_we = 0; core_wdata = 0; core_addr = 0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset state
        check_all_zero();
        check("tx_data_rst", tx_data, 8'hFF);
        check("busy_rst", {7'h0, busy}, 8'h00);
        check("ptr_rst", {4'h0, ptr}, 8'h00);
        check("wr_addr_rst", {4'h0, wr_addr}, 8'h00);

        // Pointer byte then two auto-incremented writes
        start(1'b0);
        check("busy_wr", {7'h0, busy}, 8'h01);
        rx(8'h03, 0, 0);
        rx(8'hA5, 1, 4'd3);
        rx(8'h5A, 1, 4'd4);
        stop();
        creg(4'd3, 8'hA5);
        creg(4'd4, 8'h5A);
        check("ptr_after_wr", {4'h0, ptr}, 8'h05);
        check("busy_after_stop", {7'h0, busy}, 8'h00);
        check("wr_addr_last", {4'h0, wr_addr}, 8'h04);

        // Pointer set, repeated START read, wraps 15 -> 0
        cwrite(4'd14, 8'h11);
        cwrite(4'd15, 8'h22);
        cwrite(4'd0,  8'h33);
        start(1'b0);
        rx(8'h0E, 0, 0);
        start(1'b1);
        treq(8'h11);
        treq(8'h22);
        treq(8'h33);
        check("ptr_after_rd", {4'h0, ptr}, 8'h01);
        tick();
        check("tx_data_held", tx_data, 8'h33);
        stop();

        // Collision, same register: I2C wins
        start(1'b0);
        rx(8'h02, 0, 0);
        core_we = 1'b1; core_addr = 4'd2; core_wdata = 8'h7E;
        rx(8'hC3, 1, 4'd2);
        core_we = 1'b0;
        stop();
        creg(4'd2, 8'hC3);

        // Collision, different registers: both commit
        start(1'b0);
        rx(8'h02, 0, 0);
        core_we = 1'b1; core_addr = 4'd6; core_wdata = 8'h7E;
        rx(8'hC3, 1, 4'd2);
        core_we = 1'b0;
        stop();
        creg(4'd2, 8'hC3);
        creg(4'd6, 8'h7E);
        check("ptr_after_coll", {4'h0, ptr}, 8'h03);

        // tx_req while IDLE returns FF and leaves ptr alone
        treq(8'hFF);
        check("ptr_idle_tx", {4'h0, ptr}, 8'h03);

        // Reset between received bytes
        start(1'b0);
        rx(8'h08, 0, 0);
        rx(8'h99, 1, 4'd8);
        tick();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        check_all_zero();
        check("ptr_after_reset", {4'h0, ptr}, 8'h00);
        check("busy_after_reset", {7'h0, busy}, 8'h00);
        rx(8'h77, 0, 0);
        creg(4'd0, 8'h00);

        // START and STOP together: START wins, lands in read state
        start(1'b0);
        bus_start = 1'b1; bus_dir = 1'b1; bus_stop = 1'b1;
        tick();
        bus_start = 1'b0; bus_stop = 1'b0;
        check("busy_start_stop", {7'h0, busy}, 8'h01);
        treq(8'h00);
        check("ptr_start_stop", {4'h0, ptr}, 8'h01);
        stop();

        // Write to register 0, which RO_MASK marks read-only
        start(1'b0);
        rx(8'h00, 0, 0);
`ifdef I2C_REGMAP_RO_PROTECT_EN
        rx(8'hFF, 0, 0);
`else
        rx(8'hFF, 1, 4'd0);
`endif
        check("ptr_ro", {4'h0, ptr}, 8'h01);
        stop();
`ifdef I2C_REGMAP_RO_PROTECT_EN
        creg(4'd0, 8'h00);
`else
        creg(4'd0, 8'hFF);
`endif
        cwrite(4'd0, 8'h5C);
        creg(4'd0, 8'h5C);

        // Drain and confirm no expected event was missed
        tick(); tick();
        check("tx_q_left", 8'(tx_q.size()), 8'h00);
        check("wr_q_left", 8'(wr_q.size()), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk + m_chk, n_fail + m_fail);
        $finish;
    end

endmodule

// File: doc/i2c_regmap_ctrl.md
Name: i2c_regmap_ctrl

Overview:
Sequences the byte-level downstream interface of the I2C slave into an addressable register map.
- First byte of a master write sets the register pointer; later bytes write registers with auto-increment.
- A master read streams registers from the current pointer, auto-incrementing.
- A core-side port gives local logic read/write access to the same registers.

Parameters:
NUM_REGS, 16, number of 8-bit registers; must be a power of two, at least 2.
PTR_W, $clog2(NUM_REGS), pointer width; derived, never overridden.
RESET_VAL, 8'h00, reset value of every register.
RO_MASK, '0, NUM_REGS-bit mask, bit i set = register i read-only from I2C; used only with the optional feature.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
bus_start  in  1  one-cycle pulse: START or repeated START with matching address
bus_dir  in  1  sampled with bus_start: 0 = master writes, 1 = master reads
bus_stop  in  1  one-cycle pulse: STOP seen, or master NACK ended a read
rx_valid  in  1  one-cycle pulse: rx_data holds a byte received from master
rx_data  in  8  received byte
tx_req  in  1  one-cycle pulse: slave needs the next byte to transmit
tx_valid  out  1  one-cycle pulse, exactly 1 cycle after tx_req
tx_data  out  8  byte to transmit; held until the next tx_valid
core_addr  in  PTR_W  core read/write address
core_rdata  out  8  combinational read of regs[core_addr]
core_we  in  1  core write enable
core_wdata  in  8  core write data
wr_strobe  out  1  one-cycle pulse after each committed I2C register write
wr_addr  out  PTR_W  register index of the last committed I2C write
busy  out  1  high in any state other than IDLE
ptr  out  PTR_W  current register pointer

Behaviour:
Reset values:
- All registers = RESET_VAL; ptr = 0; state = IDLE.
- tx_valid = 0, tx_data = 8'hFF, wr_strobe = 0, wr_addr = 0, busy = 0.
- A reset mid-transaction aborts it immediately; no partial write survives.

States: IDLE, GET_PTR, WRITE_DATA, READ_DATA.
- IDLE: bus_start & ~bus_dir -> GET_PTR. bus_start & bus_dir -> READ_DATA; ptr is kept, so write-pointer / repeated-START / read works.
- GET_PTR: rx_valid -> ptr <= rx_data[PTR_W-1:0] (upper bits dropped), go to WRITE_DATA.
- WRITE_DATA: rx_valid ->
  - regs[ptr] <= rx_data
  - wr_addr <= ptr
  - wr_strobe = 1 on the next cycle
  - ptr <= ptr+1, wrapping NUM_REGS-1 -> 0
- READ_DATA: tx_req ->
  - tx_data <= regs[ptr], with tx_valid = 1 on the next cycle
  - ptr <= ptr+1, wrapping
  - tx_data reflects any register write committed on or before the tx_req cycle.
- Any state: bus_stop -> IDLE; ptr is kept.
- Any non-IDLE state: bus_start re-enters GET_PTR or READ_DATA according to bus_dir.

Simultaneous and boundary events:
- bus_start and bus_stop in the same cycle: bus_start wins.
- rx_valid or tx_req in the same cycle as bus_start or bus_stop: ignored.
- rx_valid outside GET_PTR/WRITE_DATA: ignored.
- tx_req outside READ_DATA: tx_valid still pulses, with tx_data = 8'hFF; ptr unchanged.
- core_we and an I2C write to the same register in the same cycle: the I2C write wins.
- core_we and an I2C write to different registers in the same cycle: both commit.
- core_we never pulses wr_strobe and never moves ptr.

Optional Feature:
Macro I2C_REGMAP_RO_PROTECT_EN.
- Defined: an I2C write to register i with RO_MASK[i]=1 is dropped and wr_strobe does not pulse. ptr still increments. core_we is unaffected by the mask.
- Undefined: RO_MASK is ignored and all registers are I2C-writable.

Decomposition:
- Package i2c_regmap_pkg holds:
  - the state enum typedef
  - DATA_W = 8
  - IDLE_TX_BYTE = 8'hFF
- One sub-module, regmap_regfile, holds the storage:
  - I2C write port with priority over the core write port
  - registered tx read port
  - combinational core read port
- The FSM, pointer and strobe generation live in i2c_regmap_ctrl.

Test Plan:
- Reset, then read all registers via core_addr -> core_rdata = 8'h00 for all 16; tx_data = 8'hFF; busy = 0.
- Write: start(dir=0), rx 8'h03, 8'hA5, 8'h5A, stop -> regs[3]=A5, regs[4]=5A; wr_strobe pulses with wr_addr 3 then 4; ptr = 5; busy = 0 after stop.
- Pointer set then read: start(dir=0), rx 8'h0E; start(dir=1) with regs[14]=11, regs[15]=22, regs[0]=33; three tx_req -> tx_data 11, 22, 33 each 1 cycle after its tx_req (wrap checked); ptr = 1.
- Collision: same cycle, I2C write 8'hC3 to reg 2 and core_we 8'h7E to reg 2 -> reg 2 = C3. Repeat with core to reg 6 -> reg 2 = C3, reg 6 = 7E.
- Abort cases:
  - tx_req while IDLE -> tx_valid with FF, ptr unchanged.
  - reset asserted between rx bytes -> regs = 00, ptr = 0, IDLE.
  - bus_start and bus_stop together -> busy stays 1.
- With I2C_REGMAP_RO_PROTECT_EN and RO_MASK = 16'h0001: I2C write 8'hFF to reg 0 -> reg 0 unchanged, no wr_strobe, ptr = 1. core_we to reg 0 succeeds.
